// File: rtl/boot_loader.sv
`default_nettype none
// boot_loader: parses framed LOAD_I / LOAD_D / GO / HALT byte commands, writes InstrMem/DataMem, drives CPU start.
// Revision 1.0
module boot_loader #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_BYTES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr,
  output logic [7:0]                    dmem_wdata,
  output logic                          cpu_start,
  output logic                          busy,
  output logic                          err
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_BYTES);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_I_AH   = 4'd1;
  localparam logic [3:0] S_I_AL   = 4'd2;
  localparam logic [3:0] S_I_CH   = 4'd3;
  localparam logic [3:0] S_I_CL   = 4'd4;
  localparam logic [3:0] S_I_DATA = 4'd5;
  localparam logic [3:0] S_D_A    = 4'd6;
  localparam logic [3:0] S_D_C    = 4'd7;
  localparam logic [3:0] S_D_DATA = 4'd8;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_GO     = 8'h03;
  localparam logic [7:0] CMD_HALT   = 8'h04;

  localparam logic [IA-1:0] IDX_ONE   = {{(IA-1){1'b0}}, 1'b1};
  localparam logic [DA-1:0] DADDR_ONE = {{(DA-1){1'b0}}, 1'b1};

  logic [3:0]    state;
  logic [7:0]    hold;       // high byte of the 16-bit address/count fields
  logic [15:0]   cnt;
  logic [1:0]    lane;
  logic [23:0]   asm_word;   // bytes of the current word received so far
  logic [IA-1:0] idx;
  logic [DA-1:0] daddr;

  logic        acc;
  logic [15:0] pair;
  logic [31:0] word;

  assign acc  = rx_valid && rx_ready;
  assign pair = {hold, rx_data};
  assign word = {rx_data, asm_word};
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      hold       <= 8'h00;
      cnt        <= 16'h0000;
      lane       <= 2'd0;
      asm_word   <= 24'h000000;
      idx        <= '0;
      daddr      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 8'h00;
      cpu_start  <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      if (acc) begin
        case (state)
          S_IDLE: begin
            // Once the CPU runs, only HALT is honoured; loads and GO are protocol errors.
            if (cpu_start) begin
              if (rx_data == CMD_HALT) cpu_start <= 1'b0;
              else                     err       <= 1'b1;
            end else begin
              case (rx_data)
                CMD_LOAD_I: state     <= S_I_AH;
                CMD_LOAD_D: state     <= S_D_A;
                CMD_GO:     cpu_start <= 1'b1;
                CMD_HALT:   cpu_start <= 1'b0;
                default:    err       <= 1'b1;
              endcase
            end
          end
          S_I_AH: begin
            hold  <= rx_data;
            state <= S_I_AL;
          end
          S_I_AL: begin
            idx   <= pair[IA-1:0];
            state <= S_I_CH;
          end
          S_I_CH: begin
            hold  <= rx_data;
            state <= S_I_CL;
          end
          S_I_CL: begin
            cnt   <= pair;
            lane  <= 2'd0;
            state <= (pair == 16'd0) ? S_IDLE : S_I_DATA;
          end
          S_I_DATA: begin
            asm_word <= word[31:8];
            lane     <= lane + 2'd1;
            if (lane == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= idx;
              imem_wdata <= word;
              idx        <= idx + IDX_ONE;
              cnt        <= cnt - 16'd1;
              if (cnt == 16'd1) state <= S_IDLE;
            end
          end
          S_D_A: begin
            daddr <= rx_data[DA-1:0];
            state <= S_D_C;
          end
          S_D_C: begin
            cnt   <= {8'h00, rx_data};
            state <= (rx_data == 8'h00) ? S_IDLE : S_D_DATA;
          end
          S_D_DATA: begin
            dmem_we    <= 1'b1;
            dmem_addr  <= daddr;
            dmem_wdata <= rx_data;
            daddr      <= daddr + DADDR_ONE;
            cnt        <= cnt - 16'd1;
            if (cnt == 16'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// tb_boot_loader: directed command frames, outputs checked every cycle against a frame-level model.
module tb_boot_loader;

  localparam int IMEM_WORDS = 1024;
  localparam int DMEM_BYTES = 32;
  localparam int IA = 10;
  localparam int DA = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [IA-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          dmem_we;
  logic [DA-1:0] dmem_addr;
  logic [7:0]    dmem_wdata;
  logic          cpu_start;
  logic          busy;
  logic          err;

  boot_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_BYTES(DMEM_BYTES)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_start(cpu_start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: bytes of the frame in progress plus the two sticky flags.
  logic [7:0] frame[$];
  bit m_start, m_err;
  bit e_ready, e_iwe, e_dwe, e_start, e_busy, e_err;
  logic [IA-1:0] e_iaddr;
  logic [31:0]   e_idata;
  logic [DA-1:0] e_daddr;
  logic [7:0]    e_ddata;

  logic [IA+31:0] ilog[$];
  logic [DA+7:0]  dlog[$];
  logic [IA+31:0] iref[$];

  always @(negedge clk) begin : model
    bit acc;
    int n, base, cnt, k, loc;
    if (!rst) begin
      chk("rst rx_ready", rx_ready, 0);
      chk("rst imem_we", imem_we, 0);
      chk("rst imem_addr", imem_addr, 0);
      chk("rst imem_wdata", imem_wdata, 0);
      chk("rst dmem_we", dmem_we, 0);
      chk("rst dmem_addr", dmem_addr, 0);
      chk("rst dmem_wdata", dmem_wdata, 0);
      chk("rst cpu_start", cpu_start, 0);
      chk("rst busy", busy, 0);
      chk("rst err", err, 0);
      frame.delete();
      m_start = 0; m_err = 0;
      e_ready = 0; e_iwe = 0; e_dwe = 0; e_start = 0; e_busy = 0; e_err = 0;
    end else begin
      chk("rx_ready", rx_ready, e_ready);
      chk("imem_we", imem_we, e_iwe);
      if (e_iwe) begin
        chk("imem_addr", imem_addr, e_iaddr);
        chk("imem_wdata", imem_wdata, e_idata);
      end
      chk("dmem_we", dmem_we, e_dwe);
      if (e_dwe) begin
        chk("dmem_addr", dmem_addr, e_daddr);
        chk("dmem_wdata", dmem_wdata, e_ddata);
      end
      chk("cpu_start", cpu_start, e_start);
      chk("busy", busy, e_busy);
      chk("err", err, e_err);
      if (imem_we) ilog.push_back({imem_addr, imem_wdata});
      if (dmem_we) dlog.push_back({dmem_addr, dmem_wdata});

      acc = rx_valid && e_ready;
      e_iwe = 0;
      e_dwe = 0;
      if (acc) begin
        frame.push_back(rx_data);
        n = frame.size();
        if (n == 1) begin
          if (m_start) begin
            if (rx_data == 8'h04) m_start = 0; else m_err = 1;
            frame.delete();
          end else if (rx_data == 8'h03) begin
            m_start = 1; frame.delete();
          end else if (rx_data == 8'h04) begin
            m_start = 0; frame.delete();
          end else if (rx_data != 8'h01 && rx_data != 8'h02) begin
            m_err = 1; frame.delete();
          end
        end else if (frame[0] == 8'h01 && n >= 5) begin
          base = {frame[1], frame[2]};
          cnt  = {frame[3], frame[4]};
          k    = n - 6;
          if (n > 5 && (k % 4) == 3) begin
            loc     = (base + k / 4) % IMEM_WORDS;
            e_iwe   = 1;
            e_iaddr = loc[IA-1:0];
            e_idata = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
          end
          if (n == 5 + 4 * cnt) frame.delete();
        end else if (frame[0] == 8'h02 && n >= 3) begin
          cnt = frame[2];
          if (n > 3) begin
            loc     = (frame[1] + (n - 4)) % DMEM_BYTES;
            e_dwe   = 1;
            e_daddr = loc[DA-1:0];
            e_ddata = frame[n-1];
          end
          if (n == 3 + cnt) frame.delete();
        end
      end
      e_ready = 1;
      e_start = m_start;
      e_err   = m_err;
      e_busy  = (frame.size() != 0);
    end
  end

  logic [7:0] seq[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input bit gaps);
    foreach (seq[i]) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      put(seq[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    @(posedge clk);
    #2;
    idle(2);
    chk("reset rx_ready literal", rx_ready, 0);
    chk("reset busy literal", busy, 0);
    rst = 1'b1;
    idle(2);

    // Two-word instruction load at index 2.
    ilog.delete();
    seq = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h02, 8'h13, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h08, 8'h21};
    send_seq(0);
    idle(3);
    chk("t1 write count", ilog.size(), 2);
    chk("t1 word idx2", ilog[0], {10'd2, 32'h2008_0013});
    chk("t1 word idx3", ilog[1], {10'd3, 32'h2108_FFFF});
    chk("t1 busy", busy, 0);
    chk("t1 err", err, 0);

    // Data load wrapping past the top of data memory.
    dlog.delete();
    seq = '{8'h02, 8'h1E, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_seq(0);
    idle(3);
    chk("t2 write count", dlog.size(), 4);
    chk("t2 addr30", dlog[0], {5'd30, 8'hAA});
    chk("t2 addr31", dlog[1], {5'd31, 8'hBB});
    chk("t2 addr0", dlog[2], {5'd0, 8'hCC});
    chk("t2 addr1", dlog[3], {5'd1, 8'hDD});

    // Zero-count load, GO, rejected load while running, HALT.
    ilog.delete();
    dlog.delete();
    seq = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h00};
    send_seq(0);
    idle(2);
    chk("t3 zero count writes", ilog.size(), 0);
    chk("t3 busy after zero count", busy, 0);
    put(8'h03);
    chk("t3 cpu_start after GO", cpu_start, 1);
    put(8'h02);
    idle(2);
    chk("t3 err on load while running", err, 1);
    chk("t3 no data write", dlog.size(), 0);
    chk("t3 busy while running", busy, 0);
    put(8'h04);
    chk("t3 cpu_start after HALT", cpu_start, 0);

    // Illegal command byte, then a valid data load still works.
    do_reset();
    ilog.delete();
    dlog.delete();
    put(8'h7F);
    idle(2);
    chk("t4 err on illegal", err, 1);
    chk("t4 no imem writes", ilog.size(), 0);
    chk("t4 no dmem writes", dlog.size(), 0);
    seq = '{8'h02, 8'h00, 8'h01, 8'h05};
    send_seq(0);
    idle(3);
    chk("t4 write count", dlog.size(), 1);
    chk("t4 addr0", dlog[0], {5'd0, 8'h05});
    chk("t4 err sticky", err, 1);

    // Reset in the middle of a word, then a fresh one-word load.
    do_reset();
    ilog.delete();
    seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_seq(0);
    rst = 1'b0;
    idle(2);
    chk("t5 imem_we in reset", imem_we, 0);
    chk("t5 busy in reset", busy, 0);
    chk("t5 rx_ready in reset", rx_ready, 0);
    rst = 1'b1;
    idle(2);
    seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    send_seq(0);
    idle(3);
    chk("t5 write count", ilog.size(), 1);
    chk("t5 word idx0", ilog[0], {10'd0, 32'h0000_0001});

    // Three words at a truncated, wrapping index; gap-free then with random gaps.
    do_reset();
    ilog.delete();
    seq = '{8'h01, 8'hFF, 8'hFE, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    send_seq(0);
    idle(3);
    iref = ilog;
    chk("t6 write count", iref.size(), 3);
    chk("t6 word idx3FE", iref[0], {10'h3FE, 32'h4433_2211});
    chk("t6 word idx3FF", iref[1], {10'h3FF, 32'h8877_6655});
    chk("t6 word idx0", iref[2], {10'h000, 32'hCCBB_AA99});
    do_reset();
    ilog.delete();
    send_seq(1);
    idle(3);
    chk("t6 gapped write count", ilog.size(), iref.size());
    foreach (iref[i]) chk("t6 gapped write", ilog[i], iref[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader that fills the CPU's instruction memory and data memory, then releases the pipeline by driving `start`. It sits beside `CPU`, between an external byte source (UART/host bridge) and the `InstrMem`/`DataMem` write ports. It replaces bench-side memory preloading with a hardware path. A small command FSM parses framed load commands, assembles little-endian words, and issues one-cycle write strobes.

## Interface
- `IMEM_WORDS`, 1024, instruction-memory depth in 32-bit words; `imem_addr` width = clog2(IMEM_WORDS)
- `DMEM_BYTES`, 32, data-memory depth in bytes; `dmem_addr` width = clog2(DMEM_BYTES)
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  command/payload byte
- `rx_valid`  in  1  `rx_data` valid; byte accepted on a cycle with `rx_valid && rx_ready`
- `rx_ready`  out  1  loader can accept a byte
- `imem_we`  out  1  one-cycle instruction-memory write strobe
- `imem_addr`  out  clog2(IMEM_WORDS)  word index
- `imem_wdata`  out  32  assembled instruction word
- `dmem_we`  out  1  one-cycle data-memory write strobe
- `dmem_addr`  out  clog2(DMEM_BYTES)  byte address
- `dmem_wdata`  out  8  data byte
- `cpu_start`  out  1  level; drives `CPU.start`
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- Commands (first byte of a frame):
  - 0x01 LOAD_I: addr_hi, addr_lo, cnt_hi, cnt_lo, then 4×cnt payload bytes, LSB first.
  - 0x02 LOAD_D: addr, cnt, then cnt payload bytes.
  - 0x03 GO: set `cpu_start`=1.
  - 0x04 HALT: set `cpu_start`=0.
  - Any other byte in IDLE: set `err`, discard, stay in IDLE.
- FSM states: IDLE → I_AH → I_AL → I_CH → I_CL → I_DATA → IDLE; IDLE → D_A → D_C → D_DATA → IDLE. Each transition consumes one accepted byte.
- Count zero: after the last count byte the FSM returns to IDLE with no write.
- I_DATA:
  - A 2-bit byte lane counter shifts bytes into a 32-bit assembly register as {byte, reg[31:8]}.
  - On the 4th byte, register the word and write it at the current index.
  - Then increment the index and decrement the remaining count. Leave the state when the count reaches 0.
- D_DATA: each accepted byte is written at the current address; the address increments.
- Address handling: the 16-bit I address is truncated to its low clog2(IMEM_WORDS) bits. Index and D address wrap modulo depth. No error is raised for wrap or truncation.
- While `cpu_start`=1:
  - In IDLE, 0x01/0x02/0x03 set `err` and are discarded (single byte). Only 0x04 is acted on.
  - A frame in progress cannot coexist with `cpu_start`=1, because GO is only decoded in IDLE.
- `rx_ready` is 1 in every state after reset; the loader never back-pressures, because writes are single-cycle.
- Reset (`rst`=0, any time, including mid-frame):
  - FSM to IDLE; partial word discarded.
  - `rx_ready`=0, `imem_we`=0, `dmem_we`=0, `cpu_start`=0, `busy`=0, `err`=0.
  - All address/data outputs 0.

## Timing
- `rx_ready` rises on the first rising edge after `rst` deasserts.
- Write latency: `imem_we`/`dmem_we` assert in the cycle after the final payload byte of the word/byte is accepted. They stay high for exactly one cycle, with addr/wdata stable in that cycle.
- Back-to-back bytes (`rx_valid` held high) give one D write per cycle and one I write per 4 cycles. Pipelined strobes never overlap for the same memory.
- `cpu_start` changes in the cycle after the GO/HALT byte is accepted.
- `busy` is registered from the state; it is high from the cycle after the command byte until the cycle after the last frame byte.
- `err` sets in the cycle after the offending byte is accepted.
- Gaps (`rx_valid`=0) hold all state indefinitely; there is no timeout.

## Test plan
- LOAD_I 0x01,00,02,00,02 then bytes 13,00,08,20, FF,FF,08,21 → two `imem_we` pulses: idx 2 = 0x20080013 and idx 3 = 0x2108FFFF; `busy` falls afterward; `err`=0.
- LOAD_D 0x02,1E,04,AA,BB,CC,DD → `dmem_we` writes addr 30=AA, 31=BB, 0=CC, 1=DD (wrap).
- LOAD_I with cnt=0 followed by GO → no write; `cpu_start`=1 one cycle after the GO byte. A following 0x02 sets `err`=1 with no write; then HALT → `cpu_start`=0.
- Byte 0x7F in IDLE → `err`=1 with no strobes. A subsequent valid LOAD_D 0x02,00,01,05 still writes addr 0=05.
- Reset asserted after 2 of 4 payload bytes of a LOAD_I, then a new LOAD_I of one word 0x00000001 at idx 0 → only the new word is written; all outputs read their reset values during `rst`=0.
- `rx_valid` toggled randomly during a 3-word LOAD_I → writes identical to the gap-free run.
